// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-side memory responder.
// funct3 access codes and byte-lane geometry.
package data_mem_responder_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int LANES = 4;

    localparam logic [7:0] CNT_MAX = 8'hFF;

    // Saturating 8-bit increment used by the event counters.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == CNT_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/data_mem_responder_load_extender.sv
// Load alignment and sign/zero extension.
// Purely combinational; fed from the write-back register.
module load_extender
    import data_mem_responder_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] word,
    input  logic [2:0]            funct3,
    input  logic [1:0]            offset,
    output logic [DATA_WIDTH-1:0] read_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte and half out of the raw word.
    always_comb begin
        byte_sel = word[{offset, 3'b000} +: 8];
        half_sel = offset[1] ? word[31:16] : word[15:0];
    end

    // Extend according to access size and signedness.
    always_comb begin
        read_data = '0;
        unique case (funct3)
            F3_B:    read_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   read_data = {24'd0, byte_sel};
            F3_H:    read_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   read_data = {16'd0, half_sel};
            F3_W:    read_data = word;
            default: read_data = '0;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data RAM responder for the core memory stage.
// Byte-lane stores, one-cycle loads, host preload port.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           i_data_addr_M,
    input  logic [DATA_WIDTH-1:0] i_write_data_M,
    input  logic                  i_mem_write_M,
    input  logic [2:0]            i_funct3_MEM,
    output logic [DATA_WIDTH-1:0] o_read_data_WB,
    input  logic                  i_host_en,
    input  logic                  i_host_we,
    input  logic [DEPTH_LOG2-1:0] i_host_addr,
    input  logic [DATA_WIDTH-1:0] i_host_wdata,
    output logic [DATA_WIDTH-1:0] o_host_rdata,
    output logic                  o_misalign,
    output logic [7:0]            o_misalign_cnt,
    output logic [7:0]            o_collision_cnt
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [DEPTH_LOG2-1:0] core_idx;
    logic [1:0]            core_off;
    logic                  unused_addr_hi;

    logic [LANES-1:0]      lane_en;
    logic [DATA_WIDTH-1:0] lane_data;
    logic                  bad_store;

    logic                  core_store;
    logic                  store_ok;
    logic                  store_bad;
    logic                  collision;

    logic [DATA_WIDTH-1:0] wb_word;
    logic [2:0]            wb_funct3;
    logic [1:0]            wb_off;

    // Upper address bits alias the RAM and are intentionally dropped.
    assign core_idx       = i_data_addr_M[DEPTH_LOG2+1:2];
    assign core_off       = i_data_addr_M[1:0];
    assign unused_addr_hi = ^i_data_addr_M[31:DEPTH_LOG2+2];

    // Byte-lane enables, replicated store data and alignment check.
    always_comb begin
        lane_en   = '0;
        lane_data = i_write_data_M;
        bad_store = 1'b0;
        unique case (i_funct3_MEM)
            F3_B: begin
                lane_en   = 4'b0001 << core_off;
                lane_data = {4{i_write_data_M[7:0]}};
            end
            F3_H: begin
                lane_en   = core_off[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{i_write_data_M[15:0]}};
                bad_store = core_off[0];
            end
            F3_W: begin
                lane_en   = 4'b1111;
                bad_store = (core_off != 2'b00);
            end
            default: begin
                bad_store = 1'b1;
            end
        endcase
    end

    // Host wins the RAM; a competing core store is dropped.
    always_comb begin
        core_store = i_mem_write_M & ~i_host_en;
        store_ok   = core_store & ~bad_store;
        store_bad  = core_store & bad_store;
        collision  = i_mem_write_M & i_host_en;
    end

    // RAM write port: full host word or enabled core lanes.
    always_ff @(posedge clk) begin
        if (i_host_en) begin
            if (i_host_we) begin
                mem[i_host_addr] <= i_host_wdata;
            end
        end else if (store_ok) begin
            for (int i = 0; i < LANES; i++) begin
                if (lane_en[i]) begin
                    mem[core_idx][8*i +: 8] <= lane_data[8*i +: 8];
                end
            end
        end
    end

    // Write-back register: old word plus access shape, held on host cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_word   <= '0;
            wb_funct3 <= '0;
            wb_off    <= '0;
        end else if (!i_host_en) begin
            wb_word   <= mem[core_idx];
            wb_funct3 <= i_funct3_MEM;
            wb_off    <= core_off;
        end
    end

    // Host readback returns the word as it was before any write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_host_rdata <= '0;
        end else if (i_host_en) begin
            o_host_rdata <= mem[i_host_addr];
        end
    end

    // Sticky misalignment flag and its saturating counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_misalign     <= 1'b0;
            o_misalign_cnt <= '0;
        end else if (store_bad) begin
            o_misalign     <= 1'b1;
            o_misalign_cnt <= sat_inc(o_misalign_cnt);
        end
    end

    // Saturating count of core stores lost to host traffic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_collision_cnt <= '0;
        end else if (collision) begin
            o_collision_cnt <= sat_inc(o_collision_cnt);
        end
    end

    load_extender #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_load_extender (
        .word      (wb_word),
        .funct3    (wb_funct3),
        .offset    (wb_off),
        .read_data (o_read_data_WB)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder.
// Expected load data is queued at issue and popped on return.
module tb_data_mem_responder;

    logic        clk;
    logic        rst;
    logic [31:0] i_data_addr_M;
    logic [31:0] i_write_data_M;
    logic        i_mem_write_M;
    logic [2:0]  i_funct3_MEM;
    logic [31:0] o_read_data_WB;
    logic        i_host_en;
    logic        i_host_we;
    logic [7:0]  i_host_addr;
    logic [31:0] i_host_wdata;
    logic [31:0] o_host_rdata;
    logic        o_misalign;
    logic [7:0]  o_misalign_cnt;
    logic [7:0]  o_collision_cnt;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp;

    data_mem_responder #(
        .DATA_WIDTH (32),
        .DEPTH_LOG2 (8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_data_addr_M   (i_data_addr_M),
        .i_write_data_M  (i_write_data_M),
        .i_mem_write_M   (i_mem_write_M),
        .i_funct3_MEM    (i_funct3_MEM),
        .o_read_data_WB  (o_read_data_WB),
        .i_host_en       (i_host_en),
        .i_host_we       (i_host_we),
        .i_host_addr     (i_host_addr),
        .i_host_wdata    (i_host_wdata),
        .o_host_rdata    (o_host_rdata),
        .o_misalign      (o_misalign),
        .o_misalign_cnt  (o_misalign_cnt),
        .o_collision_cnt (o_collision_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic core_cyc(input logic [31:0] a, input logic [31:0] d,
                            input logic we, input logic [2:0] f3);
        i_data_addr_M  = a;
        i_write_data_M = d;
        i_mem_write_M  = we;
        i_funct3_MEM   = f3;
        i_host_en      = 1'b0;
        @(posedge clk);
        #1;
        i_mem_write_M  = 1'b0;
    endtask

    task automatic load(input logic [31:0] a, input logic [2:0] f3,
                        input logic [31:0] want);
        exp_q.push_back(want);
        core_cyc(a, 32'h0, 1'b0, f3);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (o_read_data_WB !== 32'h0) begin
            bad++; $display("FAIL reset_rd got=%h want=%h", o_read_data_WB, 32'h0);
        end
        total++;
        if (o_host_rdata !== 32'h0) begin
            bad++; $display("FAIL reset_host got=%h want=%h", o_host_rdata, 32'h0);
        end
        total++;
        if ({o_misalign, o_misalign_cnt, o_collision_cnt} !== 17'h0) begin
            bad++; $display("FAIL reset_flags got=%b/%0d/%0d want=0/0/0",
                            o_misalign, o_misalign_cnt, o_collision_cnt);
        end
        rst = 1'b0;
    endtask

    task automatic test_word;
        core_cyc(32'h10, 32'hDEADBEEF, 1'b1, 3'b010);
        load(32'h10, 3'b010, 32'hDEADBEEF);
        exp = exp_q.pop_front();
        total++;
        if (o_read_data_WB !== exp) begin
            bad++; $display("FAIL lw10 got=%h want=%h", o_read_data_WB, exp);
        end
    endtask

    task automatic test_byte;
        logic [2:0]  f3s [3];
        logic [31:0] as  [3];
        logic [31:0] ws  [3];
        f3s = '{3'b000, 3'b100, 3'b010};
        as  = '{32'h13, 32'h13, 32'h10};
        ws  = '{32'hFFFFFF80, 32'h00000080, 32'h80ADBEEF};
        core_cyc(32'h13, 32'h00000080, 1'b1, 3'b000);
        for (int i = 0; i < 3; i++) begin
            load(as[i], f3s[i], ws[i]);
            exp = exp_q.pop_front();
            total++;
            if (o_read_data_WB !== exp) begin
                bad++; $display("FAIL byte%0d got=%h want=%h", i, o_read_data_WB, exp);
            end
        end
    endtask

    task automatic test_misalign;
        logic [2:0]  f3s [4];
        logic [31:0] as  [4];
        logic [31:0] ws  [4];
        core_cyc(32'h11, 32'h00001234, 1'b1, 3'b001);
        total++;
        if (o_misalign !== 1'b1 || o_misalign_cnt !== 8'd1) begin
            bad++; $display("FAIL mis_sh got=%b/%0d want=1/1", o_misalign, o_misalign_cnt);
        end
        core_cyc(32'h10, 32'h0, 1'b1, 3'b011);
        total++;
        if (o_misalign_cnt !== 8'd2) begin
            bad++; $display("FAIL mis_f3 got=%0d want=2", o_misalign_cnt);
        end
        load(32'h10, 3'b010, 32'h80ADBEEF);
        exp = exp_q.pop_front();
        total++;
        if (o_read_data_WB !== exp) begin
            bad++; $display("FAIL mis_nowr got=%h want=%h", o_read_data_WB, exp);
        end
        core_cyc(32'h12, 32'h00008001, 1'b1, 3'b001);
        f3s = '{3'b001, 3'b101, 3'b001, 3'b110};
        as  = '{32'h12, 32'h12, 32'h10, 32'h10};
        ws  = '{32'hFFFF8001, 32'h00008001, 32'hFFFFBEEF, 32'h0};
        for (int i = 0; i < 4; i++) begin
            load(as[i], f3s[i], ws[i]);
            exp = exp_q.pop_front();
            total++;
            if (o_read_data_WB !== exp) begin
                bad++; $display("FAIL half%0d got=%h want=%h", i, o_read_data_WB, exp);
            end
        end
    endtask

    task automatic test_host;
        logic [31:0] held;
        held = o_read_data_WB;
        i_data_addr_M  = 32'h10;
        i_write_data_M = 32'h0;
        i_mem_write_M  = 1'b1;
        i_funct3_MEM   = 3'b010;
        i_host_en      = 1'b1;
        i_host_we      = 1'b1;
        i_host_addr    = 8'd4;
        i_host_wdata   = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        i_mem_write_M  = 1'b0;
        i_host_we      = 1'b0;
        total++;
        if (o_collision_cnt !== 8'd1) begin
            bad++; $display("FAIL coll got=%0d want=1", o_collision_cnt);
        end
        total++;
        if (o_host_rdata !== 32'h8001BEEF) begin
            bad++; $display("FAIL host_pre got=%h want=%h", o_host_rdata, 32'h8001BEEF);
        end
        total++;
        if (o_read_data_WB !== held) begin
            bad++; $display("FAIL wb_hold got=%h want=%h", o_read_data_WB, held);
        end
        @(posedge clk);
        #1;
        i_host_en = 1'b0;
        total++;
        if (o_host_rdata !== 32'hCAFEF00D) begin
            bad++; $display("FAIL host_rd got=%h want=%h", o_host_rdata, 32'hCAFEF00D);
        end
        load(32'h410, 3'b010, 32'hCAFEF00D);
        exp = exp_q.pop_front();
        total++;
        if (o_read_data_WB !== exp) begin
            bad++; $display("FAIL alias got=%h want=%h", o_read_data_WB, exp);
        end
    endtask

    task automatic test_rbw;
        core_cyc(32'h20, 32'h11111111, 1'b1, 3'b010);
        exp_q.push_back(32'h11111111);
        core_cyc(32'h20, 32'h22222222, 1'b1, 3'b010);
        exp = exp_q.pop_front();
        total++;
        if (o_read_data_WB !== exp) begin
            bad++; $display("FAIL rbw_old got=%h want=%h", o_read_data_WB, exp);
        end
        load(32'h20, 3'b010, 32'h22222222);
        exp = exp_q.pop_front();
        total++;
        if (o_read_data_WB !== exp) begin
            bad++; $display("FAIL rbw_new got=%h want=%h", o_read_data_WB, exp);
        end
    endtask

    task automatic test_back_to_back;
        core_cyc(32'h30, 32'h00000000, 1'b1, 3'b010);
        core_cyc(32'h30, 32'h000000AA, 1'b1, 3'b000);
        core_cyc(32'h31, 32'h000000BB, 1'b1, 3'b000);
        core_cyc(32'h33, 32'h000000CC, 1'b1, 3'b000);
        load(32'h30, 3'b010, 32'hCC00BBAA);
        exp = exp_q.pop_front();
        total++;
        if (o_read_data_WB !== exp) begin
            bad++; $display("FAIL b2b got=%h want=%h", o_read_data_WB, exp);
        end
    endtask

    task automatic test_saturate;
        core_cyc(32'h40, 32'h5555AAAA, 1'b1, 3'b010);
        for (int i = 0; i < 300; i++) begin
            core_cyc(32'h41, 32'hFFFFFFFF, 1'b1, 3'b010);
        end
        total++;
        if (o_misalign_cnt !== 8'd255 || o_misalign !== 1'b1) begin
            bad++; $display("FAIL sat got=%b/%0d want=1/255", o_misalign, o_misalign_cnt);
        end
        exp_q.push_back(32'h5555AAAA);
        exp = exp_q.pop_front();
        total++;
        if (o_read_data_WB !== exp) begin
            bad++; $display("FAIL sat_rd got=%h want=%h", o_read_data_WB, exp);
        end
        i_mem_write_M = 1'b1;
        #3;
        rst = 1'b1;
        #1;
        total++;
        if (o_read_data_WB !== 32'h0 || o_host_rdata !== 32'h0) begin
            bad++; $display("FAIL arst_data got=%h/%h want=0/0", o_read_data_WB, o_host_rdata);
        end
        total++;
        if ({o_misalign, o_misalign_cnt, o_collision_cnt} !== 17'h0) begin
            bad++; $display("FAIL arst_flags got=%b/%0d/%0d want=0/0/0",
                            o_misalign, o_misalign_cnt, o_collision_cnt);
        end
        i_mem_write_M = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        load(32'h10, 3'b100, 32'h0000000D);
        exp = exp_q.pop_front();
        total++;
        if (o_read_data_WB !== exp) begin
            bad++; $display("FAIL post_rst got=%h want=%h", o_read_data_WB, exp);
        end
    endtask

    initial begin
        rst            = 1'b1;
        i_data_addr_M  = '0;
        i_write_data_M = '0;
        i_mem_write_M  = 1'b0;
        i_funct3_MEM   = 3'b010;
        i_host_en      = 1'b0;
        i_host_we      = 1'b0;
        i_host_addr    = '0;
        i_host_wdata   = '0;
        test_reset();
        test_word();
        test_byte();
        test_misalign();
        test_host();
        test_rbw();
        test_back_to_back();
        test_saturate();
        total++;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL queue_left got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running want=done");
        $fatal(1);
    end

endmodule
